shift_unit: RTL



---
 rtl/shift_pkg.sv | 34 +++
 rtl/shift_step.sv | 67 ++++++
 rtl/shift_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared types and helpers for the multi-cycle shifter.
//   shift_mode_t  - operation select (LSL, LSR, ASR, ROR), matches the 2-bit in_mode encoding
//   shift_state_t - control FSM states
//   eff_amount()  - effective shift distance for a requested amount and mode
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

  // Linear shifts saturate at width (everything shifted out); rotates wrap.
  // width is a power of two, so the modulo reduces to a mask.
  function automatic int unsigned eff_amount(input int unsigned amount,
                                             input shift_mode_t mode,
                                             input int unsigned width);
    if (mode == SH_ROR) begin
      return amount & (width - 1);
    end else if (amount > width) begin
      return width;
    end else begin
      return amount;
    end
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-step shifter, moves value by k (0..STEP) bits.
//   value  - word to shift
//   k      - distance for this step, never above STEP
//   mode   - LSL / LSR / ASR / ROR
//   fill   - bit shifted in from the top for ASR (the original sign)
//   result - shifted word
//   carry  - last bit shifted out; for ROR the new MSB
module shift_step #(
  parameter int WIDTH = 8,
  parameter int STEP  = 4,
  parameter int K_W   = 3
) (
  input  logic [WIDTH-1:0] value,
  input  logic [K_W-1:0]   k,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  import shift_pkg::*;

  // Only the STEP bits that can enter from above matter for a right step.
  logic [STEP-1:0] upper;
  // Right window: {incoming bits, value, guard}; the guard slot at the bottom
  // makes "bit k-1 of value" a constant select at index k.
  logic [WIDTH+STEP:0] cat_r;
  // Left window: {guard, value, STEP zeros}; the top guard yields carry 0 for k=0.
  logic [WIDTH+STEP:0] cat_l;

  logic [WIDTH-1:0] res_r [STEP+1];
  logic [WIDTH-1:0] res_l [STEP+1];
  logic             car_r [STEP+1];
  logic             car_l [STEP+1];

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_upper
      assign upper[gi] = (mode == SH_ROR) ? value[gi] : ((mode == SH_ASR) & fill);
    end
  endgenerate

  assign cat_r = {upper, value, 1'b0};
  assign cat_l = {1'b0, value, {STEP{1'b0}}};

  // Every legal step distance is precomputed with constant selects and the
  // requested one is muxed out, keeping the network to STEP+1 candidates.
  generate
    for (gi = 0; gi <= STEP; gi++) begin : g_cand
      assign res_r[gi] = cat_r[gi+1 +: WIDTH];
      assign car_r[gi] = cat_r[gi];
      assign res_l[gi] = cat_l[STEP-gi +: WIDTH];
      assign car_l[gi] = cat_l[STEP+WIDTH-gi];
    end
  endgenerate

  always_comb begin
    result = res_r[k];
    carry  = car_r[k];
    if (mode == SH_LSL) begin
      result = res_l[k];
      carry  = car_l[k];
    end else if (mode == SH_ROR) begin
      carry = res_r[k][WIDTH-1];
    end
  end

endmodule

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle LSL/LSR/ASR/ROR shifter with valid/ready handshakes.
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - operation handshake (ready only while idle)
//   in_value, in_amount  - operand and unsigned shift amount (AMT_W up to 32)
//   in_mode              - 0 LSL, 1 LSR, 2 ASR, 3 ROR
//   out_valid/out_ready  - result handshake; result held until taken
//   out_value            - shifted result
//   out_carry            - last bit shifted out (ROR: result MSB), 0 for zero shifts
//   out_zero             - out_value == 0
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_carry,
  output logic             out_zero
);
  import shift_pkg::*;

  localparam int REM_W = $clog2(WIDTH + 1);
  localparam int K_W   = $clog2(STEP + 1);

  shift_state_t     state_reg;
  shift_mode_t      mode_reg;
  logic [WIDTH-1:0] value_reg;
  logic             carry_reg;
  logic             fill_reg;
  logic [REM_W-1:0] rem_reg;

  logic [REM_W-1:0] eff;
  logic [REM_W-1:0] k_full;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  assign eff    = REM_W'(eff_amount(32'(in_amount), shift_mode_t'(in_mode), WIDTH));
  assign k_full = (rem_reg < REM_W'(STEP)) ? rem_reg : REM_W'(STEP);
  assign k      = K_W'(k_full);

  shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .K_W  (K_W)
  ) u_step (
    .value (value_reg),
    .k     (k),
    .mode  (mode_reg),
    .fill  (fill_reg),
    .result(step_value),
    .carry (step_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= SH_LSL;
      value_reg <= '0;
      carry_reg <= 1'b0;
      fill_reg  <= 1'b0;
      rem_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            value_reg <= in_value;
            carry_reg <= 1'b0;
            mode_reg  <= shift_mode_t'(in_mode);
            fill_reg  <= in_value[WIDTH-1];
            rem_reg   <= eff;
            state_reg <= (eff == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          value_reg <= step_value;
          carry_reg <= step_carry;
          rem_reg   <= rem_reg - k_full;
          if (rem_reg == k_full) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign out_value = value_reg;
  assign out_carry = carry_reg;
  assign out_zero  = (value_reg == '0);

endmodule
